// File: rtl/divisor_16bits.sv
// ============================================================================
// Module   : divisor_16bits
// Brief    : Sequential restoring divider, one quotient bit per clock, with a
//            start/done handshake. Define DIVISOR_16BITS_SIGNED_EN for signed.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module divisor_16bits #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_zero,
  output logic             overflow
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             div_zero_q, div_zero_d;
  logic             done_q, done_d;

  logic [WIDTH:0]   partial;
  logic [WIDTH:0]   diff;
  logic             borrow;
  logic [WIDTH-1:0] rem_next;
  logic [WIDTH-1:0] dvd_next;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;
  logic [WIDTH-1:0] q_final;
  logic [WIDTH-1:0] r_final;

`ifdef DIVISOR_16BITS_SIGNED_EN
  logic neg_q_q, neg_q_d;
  logic neg_r_q, neg_r_d;
  logic ovf_pend_q, ovf_pend_d;
  logic overflow_q, overflow_d;

  assign mag_a   = a[WIDTH-1] ? (~a + 1'b1) : a;
  assign mag_b   = b[WIDTH-1] ? (~b + 1'b1) : b;
  assign q_final = neg_q_q ? (~dvd_next + 1'b1) : dvd_next;
  assign r_final = neg_r_q ? (~rem_next + 1'b1) : rem_next;
  assign overflow = overflow_q;
`else
  assign mag_a   = a;
  assign mag_b   = b;
  assign q_final = dvd_next;
  assign r_final = rem_next;
  assign overflow = 1'b0;
`endif

  // The partial remainder keeps its carry-out bit, so divisors with the MSB
  // set still compare correctly; the borrow of the subtract is the decision.
  assign partial  = {rem_q, dvd_q[WIDTH-1]};
  assign diff     = partial - {1'b0, dvs_q};
  assign borrow   = diff[WIDTH];
  assign rem_next = borrow ? partial[WIDTH-1:0] : diff[WIDTH-1:0];
  assign dvd_next = {dvd_q[WIDTH-2:0], ~borrow};

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    dvd_d       = dvd_q;
    dvs_d       = dvs_q;
    rem_d       = rem_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    div_zero_d  = div_zero_q;
    done_d      = 1'b0;
`ifdef DIVISOR_16BITS_SIGNED_EN
    neg_q_d     = neg_q_q;
    neg_r_d     = neg_r_q;
    ovf_pend_d  = ovf_pend_q;
    overflow_d  = overflow_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          div_zero_d = 1'b0;
`ifdef DIVISOR_16BITS_SIGNED_EN
          overflow_d = 1'b0;
          neg_q_d    = a[WIDTH-1] ^ b[WIDTH-1];
          neg_r_d    = a[WIDTH-1];
          ovf_pend_d = (a == {1'b1, {(WIDTH-1){1'b0}}}) && (b == {WIDTH{1'b1}});
`endif
          if (b == '0) begin
            // Divide by zero skips the iteration and reports immediately.
            quotient_d  = {WIDTH{1'b1}};
            remainder_d = a;
            div_zero_d  = 1'b1;
            state_d     = S_DONE;
          end else begin
            dvd_d   = mag_a;
            dvs_d   = mag_b;
            rem_d   = '0;
            cnt_d   = '0;
            state_d = S_CALC;
          end
        end
      end

      S_CALC: begin
        rem_d = rem_next;
        dvd_d = dvd_next;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST_CNT) begin
          quotient_d  = q_final;
          remainder_d = r_final;
`ifdef DIVISOR_16BITS_SIGNED_EN
          overflow_d  = ovf_pend_q;
`endif
          state_d     = S_DONE;
        end
      end

      S_DONE: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      dvd_q       <= '0;
      dvs_q       <= '0;
      rem_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      div_zero_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      dvd_q       <= dvd_d;
      dvs_q       <= dvs_d;
      rem_q       <= rem_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      div_zero_q  <= div_zero_d;
      done_q      <= done_d;
    end
  end

`ifdef DIVISOR_16BITS_SIGNED_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      neg_q_q    <= 1'b0;
      neg_r_q    <= 1'b0;
      ovf_pend_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      neg_q_q    <= neg_q_d;
      neg_r_q    <= neg_r_d;
      ovf_pend_q <= ovf_pend_d;
      overflow_q <= overflow_d;
    end
  end
`endif

  assign busy      = (state_q == S_CALC) || (state_q == S_DONE);
  assign done      = done_q;
  assign quotient  = quotient_q;
  assign remainder = remainder_q;
  assign div_zero  = div_zero_q;

endmodule

`default_nettype wire
